// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller, also used by
// decode and by the fetch testbench.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h00000013;
    localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the architectural fetch PC, issues one outstanding request
// at a time to instruction memory (req/gnt/rvalid) and hands fetched words to
// decode over valid/ready. Redirects replace the PC and squash any stale
// response still in flight.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   imem_req_o/addr_o     fetch request and word-aligned address
//   imem_gnt_i            request accepted (req & gnt = issue)
//   imem_rvalid_i/rdata_i response, one per issued request
//   redirect_i/pc_i       load a new PC, discard anything older
//   insn_valid_o/ready_i  decode handshake
//   pc_o/insn_o           presented instruction and its PC
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// REQ   | request asserted at fetch_pc, waiting for grant
// WAIT  | request issued, waiting for response (dropped if squash set)
// OUT   | instruction presented to decode until consumed
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned        DWIDTH   = 32,
    parameter int unsigned        AWIDTH   = 32,
    parameter logic [AWIDTH-1:0]  BASEADDR = 32'h01000000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DWIDTH-1:0] imem_rdata_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
);

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic              squash_q, squash_d;
    logic              valid_q, valid_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] insn_q, insn_d;
    logic [AWIDTH-1:0] redirect_pc_aligned;

    assign redirect_pc_aligned = {redirect_pc_i[AWIDTH-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= BASEADDR;
            squash_q   <= 1'b0;
            valid_q    <= 1'b0;
            pc_q       <= BASEADDR;
            insn_q     <= DWIDTH'(NOP_INSN);
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            squash_q   <= squash_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            insn_q     <= insn_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        squash_d   = squash_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        insn_d     = insn_q;

        case (state_q)
            BOOT: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_gnt_i) begin
                    state_d = WAIT;
                    // The request just granted carries the old PC.
                    if (redirect_i) squash_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    if (squash_q || redirect_i) begin
                        // Clearing squash here is safe: only one request can
                        // ever be outstanding, so this is the stale one.
                        squash_d = 1'b0;
                        state_d  = REQ;
                    end else begin
                        pc_d    = fetch_pc_q;
                        insn_d  = imem_rdata_i;
                        valid_d = 1'b1;
                        state_d = OUT;
                    end
                end else if (redirect_i) begin
                    squash_d = 1'b1;
                end
            end
            OUT: begin
                if (redirect_i) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                end else if (insn_ready_i) begin
                    fetch_pc_d = fetch_pc_q + AWIDTH'(PC_STEP);
                    valid_d    = 1'b0;
                    state_d    = REQ;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // Redirect overrides the +4/hold choice made above in every state.
        if (redirect_i) fetch_pc_d = redirect_pc_aligned;
    end

    assign imem_req_o   = (state_q == REQ);
    assign imem_addr_o  = fetch_pc_q;
    assign insn_valid_o = valid_q;
    assign pc_o         = pc_q;
    assign insn_o       = insn_q;

    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst)
        imem_req_o |-> (imem_addr_o[1:0] == 2'b00));

    a_out_stable: assert property (@(posedge clk) disable iff (!rst)
        (insn_valid_o && !insn_ready_i && !redirect_i)
            |=> (insn_valid_o && $stable(pc_o) && $stable(insn_o)));

    a_one_outstanding: assert property (@(posedge clk) disable iff (!rst)
        (imem_req_o && imem_gnt_i) |=> !imem_req_o);

    a_rvalid_in_wait: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid_i |-> (state_q == WAIT));

endmodule
